// File: rtl/data_mem_bank.sv
// data_mem_bank: byte-writable word memory behind a one-outstanding request/response FSM.
// Build option: define DMEM_RANGE_CHECK_EN to flag addr >= DEPTH requests on rsp_err.
//
// state | meaning
// IDLE  | ready for a request; zero-wait accesses execute on the acceptance edge
// WAIT  | request latched, counting down wait states; access executes when count is 1
// RESP  | response held on rsp_* until rsp_ready
module data_mem_bank #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("data_mem_bank: DATA_W must be a multiple of 8");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("data_mem_bank: DEPTH exceeds the address space");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("data_mem_bank: WAIT_CYCLES must be 0..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              exec;
  logic [ADDR_W-1:0] x_addr;
  logic              x_we;
  logic [NB-1:0]     x_be;
  logic [DATA_W-1:0] x_wdata;
  logic [IDX_W-1:0]  x_idx;
  logic              x_in_range;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;

  // A zero-wait access runs on the acceptance edge, before the latches hold the request.
  assign x_addr     = (state == IDLE) ? req_addr  : addr_q;
  assign x_we       = (state == IDLE) ? req_we    : we_q;
  assign x_be       = (state == IDLE) ? req_be    : be_q;
  assign x_wdata    = (state == IDLE) ? req_wdata : wdata_q;
  assign x_idx      = x_addr[IDX_W-1:0];
  assign x_in_range = ({1'b0, x_addr} < DEPTH_L);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    exec      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt = WAIT_L;
          if (WAIT_CYCLES == 0) begin
            exec      = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          exec      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        be_q    <= req_be;
        wdata_q <= req_wdata;
      end
      if (exec) begin
        rdata_q <= (!x_we && x_in_range) ? mem[x_idx] : '0;
      end
    end
  end

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (exec && x_we && x_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (x_be[b]) mem[x_idx][8*b +: 8] <= x_wdata[8*b +: 8];
      end
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (exec) begin
      err_q <= !x_in_range;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
